ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the mouse (e.g. 0xF4 enable data reporting, 0xFF reset) over the shared open-drain ps2_clk/ps2_data lines.
- Complements the existing PS/2 receive path in the mouse controller.
- Sits in the 75 MHz domain; the two open-drain enables are combined with the receiver at the inout pads.

Parameters:
- CLK_FREQ_HZ, 75_000_000, system clock frequency.
- INHIBIT_CYCLES, 7500, clock-low hold time before the start bit (100 µs at 75 MHz).
- TIMEOUT_CYCLES, 1_125_000, maximum time from releasing the clock to ACK completion (15 ms).
- FILTER_LEN, 8, consecutive equal samples needed to accept a new level on a synchronized PS/2 line.

Ports:
- clk  in  1  system clock, 75 MHz.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte, sampled when tx_valid && tx_ready.
- tx_valid  in  1  send request.
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse: device ACK received and bus returned idle.
- tx_err  out  1  one-cycle pulse: timeout or missing ACK.
- ps2_clk_in  in  1  raw pad level of PS/2 clock.
- ps2_data_in  in  1  raw pad level of PS/2 data.
- ps2_clk_oe  out  1  1 = drive clock line low, 0 = release.
- ps2_data_oe  out  1  1 = drive data line low, 0 = release.

Behaviour:
- Reset values: tx_ready=1 once in IDLE, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0. All counters cleared; state IDLE.
- Reset takes effect asynchronously mid-frame: both lines are released immediately.
- Input conditioning: each PS/2 input passes through 2-FF sync, then the FILTER_LEN stability filter (filtered reset level 1). A falling edge is filtered clk going 1->0; it produces a one-cycle fall pulse.
- Frame contents, LSB first:
  - start bit = 0, then d0..d7
  - parity = ~^tx_data (odd parity)
  - stop bit = 1 (line released)
- Parity arithmetic: total ones over data + parity must be odd.
- State machine:
  - IDLE: tx_ready=1. On tx_valid, latch byte, compute parity, load shift register. Go to INHIBIT next cycle. tx_valid is ignored in all other states.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the last cycle assert data_oe=1 (start bit), then go to REQ.
  - REQ: clk_oe=0, data_oe=1. Start the timeout counter and bit counter=0. Go to SHIFT.
  - SHIFT: on each fall pulse, drive the next bit (data_oe = ~bit):
    - falls 1-8: d0..d7
    - fall 9: parity
    - fall 10: stop (data_oe=0)
    - After fall 10, go to ACK.
  - ACK: on the next fall pulse, sample filtered data. 0 -> WAIT_IDLE; 1 -> ERROR.
  - WAIT_IDLE: wait until filtered clk=1 and data=1, then pulse tx_done and return to IDLE.
  - ERROR: release both lines, pulse tx_err for one cycle, return to IDLE.
- Timeout: the counter runs from REQ through WAIT_IDLE. Reaching TIMEOUT_CYCLES in any of these states sends the FSM to ERROR, even if a fall pulse arrives in the same cycle; timeout has priority.
- Data changes only on fall pulses, i.e. while the device holds clock low; never on rising edges.
- Starting INHIBIT aborts any device-to-host frame in progress. The receiver is expected to discard its partial frame; this block does not arbitrate.
- tx_done and tx_err are never asserted in the same cycle.
- Latency, tx_valid accepted to clock released: INHIBIT_CYCLES+1 cycles.

Test Plan:
- tx_data=0xF4 with a mouse BFM clocking at 12.5 kHz and ACKing. Required:
  - clk_oe high 7500 cycles, then data_oe=1 (start bit).
  - Bits sampled by the BFM on rising edges = 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Exactly one tx_done pulse, then tx_ready=1.
- tx_data=0xFF. Required: parity bit 1 and tx_done pulse.
- BFM clocks all 11 edges but leaves data high at fall 11. Required: tx_err pulse, both oe=0, no tx_done.
- BFM never clocks. Required: tx_err exactly TIMEOUT_CYCLES after REQ; lines released.
- tx_valid=1 with tx_data=0xAA asserted during SHIFT. Required: ignored; frame still carries the original byte.
- 3-cycle low glitch on ps2_clk_in during SHIFT. Required: no extra bit is shifted.
- rst asserted at bit 4. Required: both oe drop in the same cycle, and a new 0xF4 completes cleanly afterwards.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte (start, d0..d7,
// odd parity, stop) over the open-drain PS/2 clock/data lines and checks
// for the device ACK bit.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   tx_data[7:0]      command byte, captured when tx_valid && tx_ready
//   tx_valid          send request
//   tx_ready          high only while idle
//   tx_done           one-cycle pulse: ACK seen and bus back to idle
//   tx_err            one-cycle pulse: timeout or missing ACK
//   ps2_clk_in        raw pad level of PS/2 clock
//   ps2_data_in       raw pad level of PS/2 data
//   ps2_clk_oe        1 = pull clock line low
//   ps2_data_oe       1 = pull data line low
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ    = 75_000_000,
  parameter int unsigned INHIBIT_CYCLES = 7500,
  parameter int unsigned TIMEOUT_CYCLES = 1_125_000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned FCNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned INH_W  = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned SHR_W  = 10;

  // Elaboration-time sanity checks on the configuration.
  if (CLK_FREQ_HZ == 0) begin : g_bad_clk_freq
    $error("ps2_host_tx: CLK_FREQ_HZ must be non-zero");
  end
  if (INHIBIT_CYCLES < 2) begin : g_bad_inhibit
    $error("ps2_host_tx: INHIBIT_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_host_tx: TIMEOUT_CYCLES must be at least 2");
  end
  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("ps2_host_tx: FILTER_LEN must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning: index 0 = clock line, index 1 = data line.
  // -------------------------------------------------------------------------
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_filt;
  logic [FCNT_W-1:0] r_filt_cnt [2];
  logic              r_clk_filt_d;
  logic              w_clk_fall;

  // 2-FF synchronizer followed by a run-length stability filter per line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1      <= 2'b11;
      r_sync2      <= 2'b11;
      r_filt       <= 2'b11;
      r_clk_filt_d <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_filt_cnt[i] <= '0;
      end
    end else begin
      r_sync1      <= {ps2_data_in, ps2_clk_in};
      r_sync2      <= r_sync1;
      r_clk_filt_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        // A new level is accepted only after FILTER_LEN differing samples in a row.
        if (r_sync2[i] == r_filt[i]) begin
          r_filt_cnt[i] <= '0;
        end else if (r_filt_cnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
          r_filt[i]     <= r_sync2[i];
          r_filt_cnt[i] <= '0;
        end else begin
          r_filt_cnt[i] <= r_filt_cnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  assign w_clk_fall = r_clk_filt_d & ~r_filt[0];

  // -------------------------------------------------------------------------
  // Transmit state machine
  // -------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [SHR_W-1:0]   r_shift;
  logic [SHR_W-1:0]   w_shift_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [INH_W-1:0]   w_inh_nxt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [TO_W-1:0]    w_to_nxt;
  logic               r_clk_oe;
  logic               w_clk_oe_nxt;
  logic               r_data_oe;
  logic               w_data_oe_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic               w_to_active;
  logic               w_timeout;

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_inh_cnt <= w_inh_nxt;
      r_to_cnt  <= w_to_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // The timeout window covers everything after the clock is released.
  assign w_to_active = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                       (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout   = w_to_active && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_nxt     = r_bit_cnt;
    w_inh_nxt     = r_inh_cnt;
    w_to_nxt      = r_to_cnt;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          // Frame after the start bit: d0..d7, odd parity, stop.
          w_shift_nxt  = {1'b1, ~(^tx_data), tx_data};
          w_inh_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        w_inh_nxt    = r_inh_cnt + INH_W'(1);
        // Outputs are registered, so the start bit is scheduled one cycle early
        // to land in the final inhibit cycle.
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) begin
          w_data_oe_nxt = 1'b1;
        end
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b1;
          w_to_nxt      = '0;
          w_bit_nxt     = '0;
          w_state_nxt   = S_REQ;
        end
      end

      S_REQ: begin
        w_to_nxt    = r_to_cnt + TO_W'(1);
        w_state_nxt = S_SHIFT;
      end

      S_SHIFT: begin
        w_to_nxt = r_to_cnt + TO_W'(1);
        if (w_clk_fall) begin
          // Data only moves while the device holds the clock low.
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b1, r_shift[SHR_W-1:1]};
          w_bit_nxt     = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == BIT_W'(9)) begin
            w_state_nxt = S_ACK;
          end
        end
      end

      S_ACK: begin
        w_to_nxt = r_to_cnt + TO_W'(1);
        if (w_clk_fall) begin
          if (!r_filt[1]) begin
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_err_nxt     = 1'b1;
            w_state_nxt   = S_ERROR;
          end
        end
      end

      S_WAIT_IDLE: begin
        w_to_nxt = r_to_cnt + TO_W'(1);
        if (r_filt[0] && r_filt[1]) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_ERROR: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end

      default: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase

    // Timeout wins over any fall pulse or completion in the same cycle.
    if (w_timeout) begin
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b1;
      w_state_nxt   = S_ERROR;
    end
  end

  assign w_ready_nxt = (w_state_nxt == S_IDLE);

  assign tx_ready    = r_ready;
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a simple PS/2 device model on
// open-drain lines. Timing is scaled down (1 MHz nominal clock, 100-cycle
// inhibit, 3000-cycle timeout, 80-cycle device clock period).
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned INH    = 100;
  localparam int unsigned TO     = 3000;
  localparam int unsigned FL     = 8;
  localparam int          HALF   = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       bfm_clk_low;
  logic       bfm_data_low;
  logic       w_ps2_clk;
  logic       w_ps2_data;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  logic mid_ready;

  // Wired-AND of host and device pull-downs.
  assign w_ps2_clk  = ~(ps2_clk_oe | bfm_clk_low);
  assign w_ps2_data = ~(ps2_data_oe | bfm_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (w_ps2_clk),
    .ps2_data_in (w_ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #2;
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if (tx_done && tx_err) n_both++;
  end

  // Request a byte and measure the inhibit phase; returns at the first cycle
  // with the clock released.
  task automatic start_tx(input logic [7:0] d, output int n_inh, output int n_start,
                          output logic req_data_oe, output logic req_clk_oe);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_inh    = 0;
    n_start  = 0;
    while (ps2_clk_oe && n_inh < int'(INH) + 50) begin
      n_inh++;
      if (ps2_data_oe) n_start++;
      @(negedge clk);
    end
    req_data_oe = ps2_data_oe;
    req_clk_oe  = ps2_clk_oe;
  endtask

  // Device model. mode: 0 ACK, 1 no ACK, 2 tx_valid during shift,
  // 3 short clock glitch, 4 stop low after fall 4.
  task automatic bfm_frame(input int mode, output logic [10:0] bits);
    bits    = '1;
    bits[0] = w_ps2_data;
    for (int i = 1; i <= 10; i++) begin
      repeat (HALF) @(negedge clk);
      bfm_clk_low = 1'b1;
      if (mode == 4 && i == 4) begin
        repeat (HALF / 2) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      bfm_clk_low = 1'b0;
      bits[i] = w_ps2_data;
      if (mode == 2 && i == 2) begin
        mid_ready = tx_ready;
        tx_data   = 8'hAA;
        tx_valid  = 1'b1;
      end
      if (mode == 2 && i == 8) tx_valid = 1'b0;
      if (mode == 3 && i == 4) begin
        repeat (HALF / 2) @(negedge clk);
        bfm_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        bfm_clk_low = 1'b0;
      end
    end
    repeat (HALF / 2) @(negedge clk);
    if (mode != 1) bfm_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    bfm_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    bfm_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    bfm_data_low = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (n_done == d0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", tx_err); end
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
    total++; if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_f4();
    int n_inh, n_start, d0, e0;
    logic req_d, req_c;
    logic [10:0] bits, exp;
    exp = {1'b1, 1'b0, 8'hF4, 1'b0};
    d0 = n_done;
    e0 = n_err;
    start_tx(8'hF4, n_inh, n_start, req_d, req_c);
    total++; if (n_inh != int'(INH)) begin bad++; $display("FAIL f4_inhibit_len got=%0d exp=%0d", n_inh, INH); end
    total++; if (n_start != 1) begin bad++; $display("FAIL f4_start_in_inhibit got=%0d exp=1", n_start); end
    total++; if (req_d !== 1'b1 || req_c !== 1'b0) begin bad++; $display("FAIL f4_req_lines got=%b%b exp=01", req_c, req_d); end
    bfm_frame(0, bits);
    wait_done(d0);
    total++; if (bits !== exp) begin bad++; $display("FAIL f4_bits got=%b exp=%b", bits, exp); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL f4_done_count got=%0d exp=%0d", n_done - d0, 1); end
    total++; if (n_err != e0) begin bad++; $display("FAIL f4_err_count got=%0d exp=0", n_err - e0); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL f4_ready_after got=%b exp=1", tx_ready); end
  endtask

  task automatic test_ff();
    int n_inh, n_start, d0;
    logic req_d, req_c;
    logic [10:0] bits, exp;
    exp = {1'b1, 1'b1, 8'hFF, 1'b0};
    d0 = n_done;
    start_tx(8'hFF, n_inh, n_start, req_d, req_c);
    bfm_frame(0, bits);
    wait_done(d0);
    total++; if (bits[9] !== 1'b1) begin bad++; $display("FAIL ff_parity got=%b exp=1", bits[9]); end
    total++; if (bits !== exp) begin bad++; $display("FAIL ff_bits got=%b exp=%b", bits, exp); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL ff_done_count got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_nack();
    int n_inh, n_start, d0, e0;
    logic req_d, req_c;
    logic [10:0] bits;
    d0 = n_done;
    e0 = n_err;
    start_tx(8'h55, n_inh, n_start, req_d, req_c);
    bfm_frame(1, bits);
    repeat (20) @(negedge clk);
    total++; if (n_err != e0 + 1) begin bad++; $display("FAIL nack_err_count got=%0d exp=1", n_err - e0); end
    total++; if (n_done != d0) begin bad++; $display("FAIL nack_done_count got=%0d exp=0", n_done - d0); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL nack_lines got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL nack_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_timeout();
    int n_inh, n_start, d0, k;
    logic req_d, req_c;
    logic oe_c, oe_d;
    d0 = n_done;
    start_tx(8'h12, n_inh, n_start, req_d, req_c);
    k = 0;
    while (!tx_err && k < int'(TO) + 50) begin
      @(negedge clk);
      k++;
    end
    oe_c = ps2_clk_oe;
    oe_d = ps2_data_oe;
    total++; if (k != int'(TO)) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", k, TO); end
    total++; if (oe_c !== 1'b0 || oe_d !== 1'b0) begin bad++; $display("FAIL timeout_lines got=%b%b exp=00", oe_c, oe_d); end
    repeat (5) @(negedge clk);
    total++; if (n_done != d0) begin bad++; $display("FAIL timeout_done_count got=%0d exp=0", n_done - d0); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL timeout_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_valid_ignored();
    int n_inh, n_start, d0;
    logic req_d, req_c;
    logic [10:0] bits, exp;
    exp = {1'b1, 1'b1, 8'h0F, 1'b0};
    d0 = n_done;
    mid_ready = 1'bx;
    start_tx(8'h0F, n_inh, n_start, req_d, req_c);
    bfm_frame(2, bits);
    wait_done(d0);
    total++; if (mid_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", mid_ready); end
    total++; if (bits !== exp) begin bad++; $display("FAIL busy_bits got=%b exp=%b", bits, exp); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", n_done - d0); end
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL busy_no_restart got=%b exp=0", ps2_clk_oe); end
  endtask

  task automatic test_glitch();
    int n_inh, n_start, d0;
    logic req_d, req_c;
    logic [10:0] bits, exp;
    exp = {1'b1, 1'b0, 8'hF4, 1'b0};
    d0 = n_done;
    start_tx(8'hF4, n_inh, n_start, req_d, req_c);
    bfm_frame(3, bits);
    wait_done(d0);
    total++; if (bits !== exp) begin bad++; $display("FAIL glitch_bits got=%b exp=%b", bits, exp); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL glitch_done_count got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_reset_midframe();
    int n_inh, n_start, d0;
    logic req_d, req_c;
    logic [10:0] bits, exp;
    exp = {1'b1, 1'b0, 8'hF4, 1'b0};
    start_tx(8'hF4, n_inh, n_start, req_d, req_c);
    bfm_frame(4, bits);
    total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL mid_bit4_data_oe got=%b exp=1", ps2_data_oe); end
    rst = 1'b1;
    #1;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL mid_reset_lines got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
    @(negedge clk);
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after_reset got=%b exp=1", tx_ready); end
    d0 = n_done;
    start_tx(8'hF4, n_inh, n_start, req_d, req_c);
    total++; if (n_inh != int'(INH)) begin bad++; $display("FAIL mid_retry_inhibit got=%0d exp=%0d", n_inh, INH); end
    bfm_frame(0, bits);
    wait_done(d0);
    total++; if (bits !== exp) begin bad++; $display("FAIL mid_retry_bits got=%b exp=%b", bits, exp); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL mid_retry_done got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_back_to_back();
    int n_inh, n_start, d0;
    logic req_d, req_c;
    logic [10:0] bits, exp;
    exp = {1'b1, 1'b1, 8'h00, 1'b0};
    d0 = n_done;
    start_tx(8'h00, n_inh, n_start, req_d, req_c);
    bfm_frame(0, bits);
    wait_done(d0);
    total++; if (bits !== exp) begin bad++; $display("FAIL b2b_bits got=%b exp=%b", bits, exp); end
    total++; if (n_done != d0 + 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", n_done - d0); end
    total++; if (n_both != 0) begin bad++; $display("FAIL done_err_overlap got=%0d exp=0", n_both); end
  endtask

  initial begin
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
    mid_ready    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_f4();
    test_ff();
    test_nack();
    test_timeout();
    test_valid_ignored();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
